// File: rtl/retire_trace_tx.sv
// retire_trace_tx
// Commit-trace transmitter. Every instruction retired at write-back while
// tracing is enabled is captured into a record FIFO together with an 8-bit
// sequence number, then streamed out as four 32-bit words per record on a
// valid/ready interface. Purely observational: the core is never stalled;
// records that find the FIFO full are dropped and counted.
//
// Ports
//   clk, reset            core clock, asynchronous active-high reset
//   trc_en                trace enable (retires ignored when low)
//   ret_valid             an instruction retires this cycle
//   ret_pc, ret_instr     PC and instruction word of the retiring instruction
//   ret_type              one-hot format {j,u,b,s,i,r}
//   ret_rd/rs1/rs2        register indices
//   ret_rd_val            rd value after write-back
//   trc_valid/trc_ready   word stream handshake
//   trc_data              trace word (header, pc, instr, rd_val)
//   trc_sop/trc_eop       first / last word of a record
//   drop_cnt              saturating count of records dropped on full FIFO
//   fifo_level            records currently held
module retire_trace_tx #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trc_en,
  input  logic                     ret_valid,
  input  logic [31:0]              ret_pc,
  input  logic [31:0]              ret_instr,
  input  logic [5:0]               ret_type,
  input  logic [4:0]               ret_rd,
  input  logic [4:0]               ret_rs1,
  input  logic [4:0]               ret_rs2,
  input  logic [31:0]              ret_rd_val,
  output logic                     trc_valid,
  input  logic                     trc_ready,
  output logic [31:0]              trc_data,
  output logic                     trc_sop,
  output logic                     trc_eop,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

  typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;

  state_t state, state_nxt;

  logic [31:0] mem_hdr   [DEPTH];
  logic [31:0] mem_pc    [DEPTH];
  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_val   [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic [7:0]    seq;
  logic          lost;

  logic accept, full, push, drop, pop;

  // Full is judged on the registered level, so a pop in the same cycle
  // cannot make room for an arriving retire.
  assign accept = ret_valid & trc_en;
  assign full   = (level == FULL_LVL);
  assign push   = accept & ~full;
  assign drop   = accept & full;
  assign pop    = (state == W3) & trc_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      seq      <= '0;
      lost     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (accept) seq <= seq + 8'd1;
      if (drop)      lost <= 1'b1;
      else if (push) lost <= 1'b0;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Record storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_hdr[wr_ptr]   <= {seq, ret_type, lost, 2'b00, ret_rd, ret_rs1, ret_rs2};
      mem_pc[wr_ptr]    <= ret_pc;
      mem_instr[wr_ptr] <= ret_instr;
      mem_val[wr_ptr]   <= ret_rd_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    trc_valid = 1'b0;
    trc_sop   = 1'b0;
    trc_eop   = 1'b0;
    trc_data  = '0;
    case (state)
      IDLE: begin
        if (level != '0) state_nxt = W0;
      end
      W0: begin
        trc_valid = 1'b1;
        trc_sop   = 1'b1;
        trc_data  = mem_hdr[rd_ptr];
        if (trc_ready) state_nxt = W1;
      end
      W1: begin
        trc_valid = 1'b1;
        trc_data  = mem_pc[rd_ptr];
        if (trc_ready) state_nxt = W2;
      end
      W2: begin
        trc_valid = 1'b1;
        trc_data  = mem_instr[rd_ptr];
        if (trc_ready) state_nxt = W3;
      end
      W3: begin
        trc_valid = 1'b1;
        trc_eop   = 1'b1;
        trc_data  = mem_val[rd_ptr];
        // level >= 1 here; after the pop it is non-empty if more remained
        // or a retire is pushed in the same cycle.
        if (trc_ready) state_nxt = ((level != ONE_LVL) || push) ? W0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_level = level;

endmodule

// File: tb/tb_retire_trace_tx.sv
// tb_retire_trace_tx
// Directed bench for retire_trace_tx. Expected stream words are queued when
// a retire is driven and checked by a negedge monitor on each handshake;
// the monitor also checks that outputs hold steady under backpressure.
module tb_retire_trace_tx;

  logic        clk_tb = 1'b0;
  logic        reset;
  logic        trc_en;
  logic        ret_valid;
  logic [31:0] ret_pc;
  logic [31:0] ret_instr;
  logic [5:0]  ret_type;
  logic [4:0]  ret_rd;
  logic [4:0]  ret_rs1;
  logic [4:0]  ret_rs2;
  logic [31:0] ret_rd_val;
  logic        trc_valid;
  logic        trc_ready;
  logic [31:0] trc_data;
  logic        trc_sop;
  logic        trc_eop;
  logic [15:0] drop_cnt;
  logic [3:0]  fifo_level;

  retire_trace_tx #(.DEPTH(8)) dut (
    .clk        (clk_tb),
    .reset      (reset),
    .trc_en     (trc_en),
    .ret_valid  (ret_valid),
    .ret_pc     (ret_pc),
    .ret_instr  (ret_instr),
    .ret_type   (ret_type),
    .ret_rd     (ret_rd),
    .ret_rs1    (ret_rs1),
    .ret_rs2    (ret_rs2),
    .ret_rd_val (ret_rd_val),
    .trc_valid  (trc_valid),
    .trc_ready  (trc_ready),
    .trc_data   (trc_data),
    .trc_sop    (trc_sop),
    .trc_eop    (trc_eop),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clk_tb = ~clk_tb;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] sb[$];
  logic [7:0]  model_seq  = 8'd0;
  logic        model_lost = 1'b0;

  int          word_idx     = 0;
  int          records_done = 0;
  bit          have_hold    = 1'b0;
  logic [33:0] hold_vec;
  bit          prev_valid   = 1'b0;
  bit          gap_check    = 1'b0;
  int          gaps         = 0;

  // Monitor: outputs are stable at the negedge; a handshake seen here
  // completes at the following posedge.
  always @(negedge clk_tb) begin
    if (reset) begin
      word_idx   = 0;
      have_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (have_hold) begin
        compared++;
        assert ({trc_valid, trc_sop, trc_eop, trc_data} === {1'b1, hold_vec}) else begin
          mismatched++;
          $error("FAIL hold: got v=%0b sop=%0b eop=%0b data=%h, want sop=%0b eop=%0b data=%h",
                 trc_valid, trc_sop, trc_eop, trc_data, hold_vec[33], hold_vec[32], hold_vec[31:0]);
        end
      end
      if (gap_check && prev_valid && !trc_valid && sb.size() != 0) gaps++;
      prev_valid = trc_valid;
      if (trc_valid && trc_ready) begin
        compared++;
        assert (sb.size() != 0) else begin
          mismatched++;
          $error("FAIL unexpected_word: got data=%h, want no word", trc_data);
        end
        if (sb.size() != 0) begin
          logic [31:0] exp_w;
          exp_w = sb.pop_front();
          compared++;
          assert ({trc_sop, trc_eop, trc_data} === {word_idx == 0, word_idx == 3, exp_w}) else begin
            mismatched++;
            $error("FAIL word%0d: got sop=%0b eop=%0b data=%h, want sop=%0b eop=%0b data=%h",
                   word_idx, trc_sop, trc_eop, trc_data, word_idx == 0, word_idx == 3, exp_w);
          end
          word_idx = (word_idx + 1) % 4;
          if (word_idx == 0) records_done++;
        end
        have_hold = 1'b0;
      end else if (trc_valid) begin
        have_hold = 1'b1;
        hold_vec  = {trc_sop, trc_eop, trc_data};
      end else begin
        have_hold = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_tb);
    #1;
  endtask

  // Called at posedge+1; the retire is captured at the next posedge.
  task automatic retire(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [5:0] typ, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] val, input bit exp_push);
    ret_valid  = 1'b1;
    ret_pc     = pc;
    ret_instr  = instr;
    ret_type   = typ;
    ret_rd     = rd;
    ret_rs1    = rs1;
    ret_rs2    = rs2;
    ret_rd_val = val;
    if (trc_en) begin
      if (exp_push) begin
        sb.push_back({model_seq, typ, model_lost, 2'b00, rd, rs1, rs2});
        sb.push_back(pc);
        sb.push_back(instr);
        sb.push_back(val);
        model_lost = 1'b0;
      end else begin
        model_lost = 1'b1;
      end
      model_seq = model_seq + 8'd1;
    end
    step();
    ret_valid = 1'b0;
  endtask

  task automatic add_retire(input bit exp_push);
    retire(32'h0000_0100, 32'h0020_81B3, 6'b000001, 5'd3, 5'd1, 5'd2, 32'h0000_000A, exp_push);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    model_seq  = 8'd0;
    model_lost = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_drain_left"}, sb.size(), 0);
    chk({tag, "_idle_valid"}, trc_valid, 0);
    chk({tag, "_idle_level"}, fifo_level, 0);
  endtask

  initial begin
    int r0;
    int n;
    logic [3:0] pat;
    reset      = 1'b1;
    trc_en     = 1'b1;
    trc_ready  = 1'b1;
    ret_valid  = 1'b0;
    ret_pc     = '0;
    ret_instr  = '0;
    ret_type   = '0;
    ret_rd     = '0;
    ret_rs1    = '0;
    ret_rs2    = '0;
    ret_rd_val = '0;
    #1;
    chk("rst_valid", trc_valid, 0);
    chk("rst_sop", trc_sop, 0);
    chk("rst_eop", trc_eop, 0);
    chk("rst_data", trc_data, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_level", fifo_level, 0);
    step();
    reset = 1'b0;

    // Single retire with latency checks.
    add_retire(1'b1);
    chk("lat_level", fifo_level, 1);
    chk("lat_idle", trc_valid, 0);
    step();
    chk("lat_valid", trc_valid, 1);
    chk("lat_sop", trc_sop, 1);
    chk("lat_hdr", trc_data, 32'h0004_0C22);
    wait_drain("single");

    // Backpressure with ready pattern 1,0,0,1 repeating.
    pat = 4'b1001;
    r0 = records_done;
    trc_ready = 1'b0;
    add_retire(1'b1);
    n = 0;
    while (sb.size() != 0 && n < 64) begin
      trc_ready = pat[3 - (n % 4)];
      step();
      n++;
    end
    trc_ready = 1'b1;
    chk("bp_records", records_done - r0, 1);
    wait_drain("bp");

    // Overflow: 8 pushed, 2 dropped, then a lost-flagged record.
    do_reset();
    trc_ready = 1'b0;
    for (int k = 0; k < 10; k++)
      retire(32'h0000_1000 + 32'(4 * k), 32'h0000_0013 + 32'(k << 7),
             6'b000010, 5'(k + 1), 5'(k), 5'(31 - k), 32'(k * 3), k < 8);
    chk("ovf_level", fifo_level, 8);
    chk("ovf_drop", drop_cnt, 2);
    trc_ready = 1'b1;
    r0 = records_done;
    n = 0;
    while (records_done == r0 && n < 50) begin
      step();
      n++;
    end
    chk("ovf_pop", records_done - r0, 1);
    chk("ovf_seq_model", model_seq, 10);
    retire(32'h0000_2000, 32'h0000_006F, 6'b100000, 5'd1, 5'd0, 5'd0, 32'h0000_2004, 1'b1);
    wait_drain("ovf");
    chk("ovf_drop_after", drop_cnt, 2);

    // Sequence wrap with one retire every 4 cycles; stream must be gapless.
    do_reset();
    gaps = 0;
    gap_check = 1'b1;
    for (int k = 0; k < 260; k++) begin
      retire(32'h0001_0000 + 32'(4 * k), 32'($urandom), 6'd1 << (k % 6),
             5'(k), 5'(k + 7), 5'(k + 13), 32'($urandom), 1'b1);
      repeat (3) step();
    end
    wait_drain("wrap");
    gap_check = 1'b0;
    chk("wrap_gaps", gaps, 0);
    chk("wrap_drop", drop_cnt, 0);

    // Reset during W2 with three records queued.
    trc_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      retire(32'h0000_3000 + 32'(4 * k), 32'h0000_0033, 6'b000001, 5'd5, 5'd6, 5'd7, 32'(k), 1'b1);
    trc_ready = 1'b1;
    repeat (2) step();
    trc_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_valid", trc_valid, 0);
    chk("mid_level", fifo_level, 0);
    chk("mid_drop", drop_cnt, 0);
    sb.delete();
    model_seq  = 8'd0;
    model_lost = 1'b0;
    step();
    reset = 1'b0;
    trc_ready = 1'b1;
    retire(32'h0000_4000, 32'h0000_0093, 6'b000010, 5'd9, 5'd8, 5'd0, 32'h55AA_55AA, 1'b1);
    wait_drain("mid");

    // Retires with tracing disabled leave no trace.
    trc_en = 1'b0;
    for (int k = 0; k < 5; k++) add_retire(1'b1);
    repeat (3) step();
    chk("en_level", fifo_level, 0);
    chk("en_valid", trc_valid, 0);
    chk("en_drop", drop_cnt, 0);
    trc_en = 1'b1;
    add_retire(1'b1);
    wait_drain("en");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/retire_trace_tx.md
# retire_trace_tx

Commit-trace transmitter for the pipelined RISC-V core. Captures each instruction retired at write-back (PC, instruction word, format flags, register indices, destination value) into a record FIFO, then serialises every record as four 32-bit words on a valid/ready stream. A lockstep checker or trace sink consumes the stream, so the core's retirement is observable outside simulation hierarchy taps. Sits beside the WB stage of `top`; purely observational, never stalls the core.

## Interface
- DEPTH, 8: record FIFO depth in records; power of two, ≥2.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- trc_en  in  1  trace enable; when 0, retires are ignored (not counted, not sequenced).
- ret_valid  in  1  one instruction retires this cycle.
- ret_pc  in  32  PC of retiring instruction.
- ret_instr  in  32  instruction word.
- ret_type  in  6  one-hot format {j,u,b,s,i,r} (bit5=j … bit0=r).
- ret_rd / ret_rs1 / ret_rs2  in  5 each  register indices.
- ret_rd_val  in  32  register-file value of rd after write-back.
- trc_valid  out  1  trc_data holds a valid word.
- trc_ready  in  1  sink accepts word when trc_valid & trc_ready.
- trc_data  out  32  trace word.
- trc_sop / trc_eop  out  1 each  first / last word of a record.
- drop_cnt  out  16  records dropped due to full FIFO, saturating.
- fifo_level  out  $clog2(DEPTH)+1  records currently held.

## Operation
- Retire accepted when ret_valid & trc_en. Each accepted retire increments the 8-bit sequence counter `seq` (wraps 255→0), whether pushed or dropped.
- Push: if FIFO not full (registered level < DEPTH at that edge), record is written with current seq value. Full is evaluated before any same-cycle pop: a retire arriving while full is dropped even if a pop completes that cycle.
- Drop: drop_cnt += 1, saturating at 0xFFFF; sticky `lost` flag set. Next pushed record carries lost=1, then lost clears (same-cycle drop+push impossible since full blocks push).
- Record word 0 (header): [31:24] seq, [23:18] ret_type, [17] lost, [16:15] 2'b00, [14:10] rd, [9:5] rs1, [4:0] rs2. Word 1 = pc, word 2 = instr, word 3 = rd_val.
- Output FSM: IDLE, W0, W1, W2, W3.
  - IDLE → W0 when FIFO non-empty.
  - Wn → Wn+1 on handshake (trc_valid & trc_ready); otherwise hold.
  - W3 on handshake: pop record; → W0 if FIFO still non-empty after pop (counting a same-cycle push), else IDLE.
- trc_valid=1 in W0–W3; trc_sop=1 only in W0; trc_eop=1 only in W3. trc_data driven from FIFO head selected by state.
- fifo_level = pushes − pops; simultaneous push and pop leaves it unchanged.
- trc_en deasserted mid-stream: records already queued still drain fully.

## Timing
- Reset: trc_valid, trc_sop, trc_eop, trc_data, drop_cnt, fifo_level all 0; seq=0, lost=0, FIFO empty, state IDLE. Asserting reset mid-record aborts it immediately (trc_valid falls asynchronously); no partial record resumes.
- Latency: retire at edge N into empty FIFO with IDLE → fifo_level=1 after N; state W0, trc_valid=1 after edge N+1.
- Throughput: one word per cycle with trc_ready held high; back-to-back records with no bubble (W3→W0); 4 cycles per record minimum.
- Stability: while trc_valid & !trc_ready, trc_data/sop/eop held constant.
- Sink slower than 1 record / 4 cycles for a sustained period → FIFO fills → drops, reported via drop_cnt and lost bit.

## Test plan
- Single retire: pc=0x00000100, instr=0x002081B3 (add x3,x1,x2), type=6'b000001, rd=3, rs1=1, rs2=2, rd_val=0x0000000A, ready=1 → words 0x00040C22 (sop), 0x00000100, 0x002081B3, 0x0000000A (eop) on consecutive cycles starting 2 edges after retire.
- Backpressure: same record, trc_ready toggled 1,0,0,1,… → each word held stable while ready=0; exactly 4 handshakes, sop/eop once each.
- Overflow: DEPTH=8, trc_ready=0, 10 consecutive retires → fifo_level=8, drop_cnt=2; then 1 retire after ready raised and one pop done → that record's header bit17=1, seq=10; earlier records seq 0–7 with lost=0.
- Seq wrap and back-to-back: 260 retires, ready=1, one retire every 4 cycles → no drops, seq in headers 0…255,0…3, no idle cycle between records.
- Reset mid-record: reset pulsed during W2 with 3 records queued → trc_valid=0 immediately, fifo_level=0, drop_cnt=0; next retire emits seq=0.
- trc_en=0 with ret_valid pulses → no records, seq and drop_cnt unchanged.
